mdu_seq: RTL
============

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have: En  in  1  E-stage instruction is an MDU op (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).
REQ-004 SHALL have: Start  in  1  E-stage op is mult/multu/div/divu.
REQ-005 SHALL have: MDUop  in  3  op code: 000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mflo, 110 mthi, 111 mtlo.
REQ-006 SHALL have: A  in  32  rs operand (E stage, forwarded).
REQ-007 SHALL have: B  in  32  rt operand (E stage, forwarded).
REQ-008 SHALL have: D_MDU  in  1  D-stage instruction is any MDU op.
REQ-009 SHALL have: Busy  out  1  multi-cycle operation in progress.
REQ-010 SHALL have: Stall  out  1  freeze request to pipeline (PC, F/D hold; D/E bubble).
REQ-011 SHALL have: Out  out  32  mfhi/mflo read data to E-stage result mux.
REQ-012 SHALL have: HI  out  32, LO  out  32  architectural registers, for debug.

Function
REQ-013 States SHALL be IDLE and RUN; counter cnt SHALL be 4 bits.
REQ-014 In IDLE, En&Start at posedge SHALL latch A, B, MDUop, load cnt=5 (mult/multu) or cnt=10 (div/divu), enter RUN.
REQ-015 In RUN, cnt SHALL decrement each posedge; at posedge with cnt==1 SHALL write HI/LO, cnt->0, return to IDLE.
REQ-016 Busy SHALL be 1 exactly in RUN: 5 cycles for mult/multu, 10 for div/divu, starting the cycle after the Start edge.
REQ-017 HI/LO results SHALL be visible the first cycle Busy==0 after completion.
REQ-018 mult: {HI,LO} SHALL equal signed 64-bit A*B; multu: unsigned A*B.
REQ-019 div: LO SHALL equal signed A/B truncated toward zero, HI signed remainder (sign of A); divu: unsigned quotient/remainder.
REQ-020 div/divu with latched B==0 SHALL leave HI and LO unchanged; timing SHALL be unchanged (10 cycles).
REQ-021 mthi/mtlo (En, IDLE) SHALL write A into HI/LO at that posedge, single cycle, no Busy.
REQ-022 Out SHALL be combinational: HI when MDUop==100, LO otherwise.
REQ-023 Stall SHALL equal D_MDU & (Busy | (En & Start)); combinational, no registered delay.
REQ-024 En&Start, mthi, or mtlo while in RUN SHALL be ignored; no state change.
REQ-025 Operands SHALL be sampled only at the Start edge; later changes on A/B SHALL not affect the result.
REQ-026 En==0 SHALL cause no HI/LO/state change regardless of Start and MDUop.

Reset
REQ-027 reset SHALL asynchronously force IDLE, cnt=0, HI=0, LO=0, Busy=0, latched operands=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no HI/LO write after release.
REQ-029 After reset release, Stall SHALL be 0 unless D_MDU&En&Start holds in the same cycle.

Verification
REQ-030 mult A=-3 (FFFFFFFD), B=7 -> Busy high 5 cycles; then HI=FFFFFFFF, LO=FFFFFFEB.
REQ-031 divu A=100, B=7 -> Busy high 10 cycles; then LO=14 (0000000E), HI=2; div A=-7, B=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
REQ-032 mthi A=12345678, then div with B=0 -> HI stays 12345678 after 10 Busy cycles, LO unchanged.
REQ-033 Start mult with D_MDU=1 held -> Stall=1 in Start cycle and all 5 Busy cycles, 0 on the next; mfhi then reads the new HI on Out.
REQ-034 Start div, assert reset at Busy cycle 4 -> Busy=0, HI=LO=0 immediately, remain 0 for 12 cycles.
REQ-035 During mult RUN, drive En&Start with divu and mtlo -> ignored; final HI/LO match the original mult only.

Source files
------------

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers for a 5-stage MIPS pipeline.
// An E-stage mult/multu/div/divu starts a fixed-latency run: 5 cycles to multiply,
// 10 to divide. mthi/mtlo write HI/LO in one cycle. mfhi/mflo read back through Out.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   En, Start, MDUop E-stage MDU op valid, multi-cycle start, op code
//   A, B             E-stage operands (rs, rt)
//   D_MDU            D-stage instruction is an MDU op
//   Busy, Stall      run in progress; pipeline freeze request
//   Out              mfhi/mflo read data
//   HI, LO           architectural result registers
module mdu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic        Start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_MDU,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] Out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] MUL_CYCLES = CW'(5);
    localparam logic [CW-1:0] DIV_CYCLES = CW'(10);

    localparam logic [2:0] OP_MFHI = 3'b100;
    localparam logic [2:0] OP_MTHI = 3'b110;
    localparam logic [2:0] OP_MTLO = 3'b111;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    // op_q[1]: divide, op_q[0]: unsigned
    logic [1:0]      op_q;

    logic [2*DW-1:0] prod_s;
    logic [2*DW-1:0] prod_u;
    logic [DW-1:0]   abs_a;
    logic [DW-1:0]   abs_b;
    logic [DW-1:0]   mag_q;
    logic [DW-1:0]   mag_r;
    logic [DW-1:0]   quo_s;
    logic [DW-1:0]   rem_s;
    logic [DW-1:0]   quo_u;
    logic [DW-1:0]   rem_u;

    // Result datapath works only from the operands latched at the start edge
    always_comb begin
        prod_s = {{DW{a_q[DW-1]}}, a_q} * {{DW{b_q[DW-1]}}, b_q};
        prod_u = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
        abs_a  = a_q[DW-1] ? DW'(-a_q) : a_q;
        abs_b  = b_q[DW-1] ? DW'(-b_q) : b_q;
        // Magnitude divide keeps truncation toward zero and defines -2^31 / -1
        mag_q  = (abs_b != '0) ? abs_a / abs_b : '0;
        mag_r  = (abs_b != '0) ? abs_a % abs_b : '0;
        quo_s  = (a_q[DW-1] ^ b_q[DW-1]) ? DW'(-mag_q) : mag_q;
        rem_s  = a_q[DW-1] ? DW'(-mag_r) : mag_r;
        quo_u  = (b_q != '0) ? a_q / b_q : '0;
        rem_u  = (b_q != '0) ? a_q % b_q : '0;
    end

    // Control FSM, operand latch and HI/LO update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (En) begin
                        if (Start) begin
                            a_q   <= A;
                            b_q   <= B;
                            op_q  <= MDUop[1:0];
                            cnt   <= MDUop[1] ? DIV_CYCLES : MUL_CYCLES;
                            state <= RUN;
                        end else if (MDUop == OP_MTHI) begin
                            HI <= A;
                        end else if (MDUop == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        case (op_q)
                            2'b00: {HI, LO} <= prod_s;
                            2'b01: {HI, LO} <= prod_u;
                            2'b10: if (b_q != '0) begin
                                       HI <= rem_s;
                                       LO <= quo_s;
                                   end
                            default: if (b_q != '0) begin
                                       HI <= rem_u;
                                       LO <= quo_u;
                                   end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy  = (state == RUN);
    // Freeze D while the unit is, or is about to become, busy
    assign Stall = D_MDU & (Busy | (En & Start));
    assign Out   = (MDUop == OP_MFHI) ? HI : LO;

endmodule
